// File: rtl/data_manager_unit.sv
// RV32I load/store unit: issues byte/half/word accesses on an Avalon-MM host port
// and returns the extended load result with a single-cycle completion strobe.
module data_manager_unit (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        start_i,
  input  logic        is_store_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] store_data_i,
  output logic [31:0] address_o,
  output logic        read_o,
  output logic        write_o,
  output logic [3:0]  byteenable_o,
  output logic [31:0] host_to_agent_o,
  input  logic [31:0] agent_to_host_i,
  input  logic        waitrequest_i,
  input  logic        readdatavalid_i,
  output logic [31:0] load_data_o,
  output logic        ready_o,
  output logic        misaligned_o,
  output logic        busy_o
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_REQ = 2'd1, S_WAIT = 2'd2} state_e;

  state_e      state_q, state_d;
  logic [31:0] address_q, address_d;
  logic        read_q, read_d, write_q, write_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] wdata_q, wdata_d;
  logic [1:0]  off_q, off_d;
  logic [2:0]  f3_q, f3_d;
  logic [31:0] load_data_q, load_data_d;
  logic        ready_q, ready_d, mis_q, mis_d;

  logic        is_b, is_h, mis;
  logic [15:0] half_lane;
  logic [7:0]  byte_lane;
  logic [31:0] extracted;

  // Unused funct3 codes fall into the word case because only [1:0] selects width.
  assign is_b = (funct3_i[1:0] == 2'b00);
  assign is_h = (funct3_i[1:0] == 2'b01);
  assign mis  = is_h ? addr_i[0] : (is_b ? 1'b0 : (addr_i[1:0] != 2'b00));

  assign half_lane = off_q[1] ? agent_to_host_i[31:16] : agent_to_host_i[15:0];
  assign byte_lane = off_q[0] ? half_lane[15:8] : half_lane[7:0];

  always_comb begin
    case (f3_q[1:0])
      2'b00:   extracted = {{24{byte_lane[7] & ~f3_q[2]}}, byte_lane};
      2'b01:   extracted = {{16{half_lane[15] & ~f3_q[2]}}, half_lane};
      default: extracted = agent_to_host_i;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= S_IDLE;
      address_q   <= '0;
      read_q      <= 1'b0;
      write_q     <= 1'b0;
      be_q        <= '0;
      wdata_q     <= '0;
      off_q       <= '0;
      f3_q        <= '0;
      load_data_q <= '0;
      ready_q     <= 1'b0;
      mis_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      address_q   <= address_d;
      read_q      <= read_d;
      write_q     <= write_d;
      be_q        <= be_d;
      wdata_q     <= wdata_d;
      off_q       <= off_d;
      f3_q        <= f3_d;
      load_data_q <= load_data_d;
      ready_q     <= ready_d;
      mis_q       <= mis_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start_i && !mis) state_d = S_REQ;
      S_REQ:   if (!waitrequest_i) state_d = write_q ? S_IDLE : S_WAIT;
      S_WAIT:  if (readdatavalid_i) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    address_d   = address_q;
    read_d      = read_q;
    write_d     = write_q;
    be_d        = be_q;
    wdata_d     = wdata_q;
    off_d       = off_q;
    f3_d        = f3_q;
    load_data_d = load_data_q;
    ready_d     = 1'b0;
    mis_d       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          if (mis) begin
            mis_d = 1'b1;
          end else begin
            address_d = {addr_i[31:2], 2'b00};
            read_d    = ~is_store_i;
            write_d   = is_store_i;
            off_d     = addr_i[1:0];
            f3_d      = funct3_i;
            if (is_b) begin
              be_d    = 4'b0001 << addr_i[1:0];
              wdata_d = {4{store_data_i[7:0]}};
            end else if (is_h) begin
              be_d    = addr_i[1] ? 4'b1100 : 4'b0011;
              wdata_d = {2{store_data_i[15:0]}};
            end else begin
              be_d    = 4'b1111;
              wdata_d = store_data_i;
            end
          end
        end
      end
      S_REQ: begin
        if (!waitrequest_i) begin
          read_d  = 1'b0;
          write_d = 1'b0;
          ready_d = write_q;
        end
      end
      S_WAIT: begin
        if (readdatavalid_i) begin
          load_data_d = extracted;
          ready_d     = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign address_o       = address_q;
  assign read_o          = read_q;
  assign write_o         = write_q;
  assign byteenable_o    = be_q;
  assign host_to_agent_o = wdata_q;
  assign load_data_o     = load_data_q;
  assign ready_o         = ready_q;
  assign misaligned_o    = mis_q;
  assign busy_o          = (state_q != S_IDLE);

endmodule

// File: tb/tb_data_manager_unit.sv
// Bench for data_manager_unit: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against a transaction-level model.
module tb_data_manager_unit;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        start = 1'b0, is_store = 1'b0;
  logic [2:0]  f3 = 3'b0;
  logic [31:0] addr = '0, sd = '0, a2h = '0;
  logic        waitreq = 1'b0, rdv = 1'b0;

  logic [31:0] address, h2a, load_data;
  logic        read, write, ready, mis, busy;
  logic [3:0]  be;

  int n_cmp = 0, n_err = 0, n_cmds = 0;
  logic prev_cmd = 1'b0;

  data_manager_unit dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .is_store_i(is_store),
    .funct3_i(f3), .addr_i(addr), .store_data_i(sd),
    .address_o(address), .read_o(read), .write_o(write), .byteenable_o(be),
    .host_to_agent_o(h2a), .agent_to_host_i(a2h), .waitrequest_i(waitreq),
    .readdatavalid_i(rdv), .load_data_o(load_data), .ready_o(ready),
    .misaligned_o(mis), .busy_o(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic int nbytes(input logic [2:0] f);
    if (f[1:0] == 2'b00) return 1;
    if (f[1:0] == 2'b01) return 2;
    return 4;
  endfunction

  function automatic bit is_mis(input logic [2:0] f, input logic [31:0] a);
    return (a % nbytes(f)) != 0;
  endfunction

  function automatic logic [3:0] exp_be(input logic [2:0] f, input logic [1:0] off);
    logic [3:0] m;
    m = (nbytes(f) == 1) ? 4'b0001 : (nbytes(f) == 2) ? 4'b0011 : 4'b1111;
    return m << off;
  endfunction

  function automatic logic [31:0] exp_load(input logic [2:0] f, input logic [1:0] off, input logic [31:0] w);
    logic [31:0] mask, lane;
    if (nbytes(f) == 4) return w;
    mask = (nbytes(f) == 1) ? 32'hFF : 32'hFFFF;
    lane = (w >> (8 * off)) & mask;
    if (!f[2] && ((lane & ((mask >> 1) + 1)) != 0)) lane = lane | ~mask;
    return lane;
  endfunction

  // Model: at most one outstanding access, described by what remains to happen.
  int          m_phase;  // 0 none, 1 command on bus, 2 awaiting read data
  logic        m_store, m_ready, m_mis;
  logic [2:0]  m_f3;
  logic [31:0] m_a, m_sd, m_ld;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase = 0; m_store = 0; m_ready = 0; m_mis = 0;
      m_f3 = 0; m_a = 0; m_sd = 0; m_ld = 0;
    end else begin
      m_ready = 0;
      m_mis   = 0;
      if (m_phase == 0) begin
        if (start) begin
          if (is_mis(f3, addr)) m_mis = 1;
          else begin
            m_phase = 1; m_store = is_store; m_f3 = f3; m_a = addr; m_sd = sd;
          end
        end
      end else if (m_phase == 1) begin
        if (!waitreq) begin
          if (m_store) begin m_ready = 1; m_phase = 0; end
          else m_phase = 2;
        end
      end else if (rdv) begin
        m_ld = exp_load(m_f3, m_a[1:0], a2h);
        m_ready = 1;
        m_phase = 0;
      end
    end
  end

  always @(negedge clk) begin
    logic [31:0] lanes;
    logic [3:0]  eb;
    if ((read || write) && !prev_cmd) n_cmds++;
    prev_cmd = read || write;
    if (rst_n) begin
      chk("m_read", read, (m_phase == 1) && !m_store);
      chk("m_write", write, (m_phase == 1) && m_store);
      chk("m_busy", busy, m_phase != 0);
      chk("m_ready", ready, m_ready);
      chk("m_mis", mis, m_mis);
      chk("m_load_data", load_data, m_ld);
      if (m_phase == 1) begin
        eb = exp_be(m_f3, m_a[1:0]);
        chk("m_address", address, {m_a[31:2], 2'b00});
        chk("m_be", be, eb);
        if (m_store) begin
          lanes = {{8{eb[3]}}, {8{eb[2]}}, {8{eb[1]}}, {8{eb[0]}}};
          chk("m_wdata", h2a & lanes, (m_sd << (8 * m_a[1:0])) & lanes);
        end
      end
    end
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic issue(input logic st, input logic [2:0] f, input logic [31:0] a, input logic [31:0] d);
    start = 1; is_store = st; f3 = f; addr = a; sd = d;
    step();
    start = 0;
  endtask

  task automatic do_load(input string name, input logic [2:0] f, input logic [31:0] a,
                         input logic [31:0] data, input logic [3:0] be_exp, input logic [31:0] exp);
    waitreq = 0;
    issue(0, f, a, 0);
    chk({name, "_be"}, be, be_exp);
    step();
    a2h = data; rdv = 1;
    step();
    rdv = 0;
    chk({name, "_ready"}, ready, 1);
    chk({name, "_data"}, load_data, exp);
  endtask

  initial begin
    int c0;
    step();
    chk("rst_read", read, 0);      chk("rst_write", write, 0);
    chk("rst_addr", address, 0);   chk("rst_be", be, 0);
    chk("rst_h2a", h2a, 0);        chk("rst_ld", load_data, 0);
    chk("rst_ready", ready, 0);    chk("rst_mis", mis, 0);
    chk("rst_busy", busy, 0);
    step(); rst_n = 1; step();

    // LW with two wait states
    waitreq = 1;
    issue(0, 3'b010, 32'h100, 0);
    chk("lw_read1", read, 1); chk("lw_addr", address, 32'h100);
    step(); chk("lw_read2", read, 1);
    step(); chk("lw_read3", read, 1); waitreq = 0;
    step(); chk("lw_read_off", read, 0); chk("lw_busy", busy, 1);
    step(); a2h = 32'hDEADBEEF; rdv = 1;
    step(); rdv = 0;
    chk("lw_ready", ready, 1); chk("lw_data", load_data, 32'hDEADBEEF); chk("lw_idle", busy, 0);
    step(); chk("lw_ready_pulse", ready, 0); chk("lw_hold", load_data, 32'hDEADBEEF);

    do_load("lb",  3'b000, 32'h203, 32'h80FF_0000, 4'b1000, 32'hFFFF_FF80);
    do_load("lbu", 3'b100, 32'h203, 32'h80FF_0000, 4'b1000, 32'h0000_0080);
    do_load("lh",  3'b001, 32'h402, 32'h9234_5678, 4'b1100, 32'hFFFF_9234);
    do_load("lhu", 3'b101, 32'h400, 32'h1234_F678, 4'b0011, 32'h0000_F678);

    // SH zero wait
    waitreq = 0;
    issue(1, 3'b001, 32'h302, 32'h1234ABCD);
    chk("sh_write", write, 1); chk("sh_addr", address, 32'h300);
    chk("sh_be", be, 4'b1100); chk("sh_data", h2a[31:16], 16'hABCD);
    step(); chk("sh_write_off", write, 0); chk("sh_ready", ready, 1);

    // Misaligned accesses
    step();
    issue(0, 3'b010, 32'h101, 0);
    chk("mis_lw", mis, 1); chk("mis_lw_rd", read, 0); chk("mis_lw_rdy", ready, 0); chk("mis_lw_busy", busy, 0);
    step(); chk("mis_lw_pulse", mis, 0); chk("mis_lw_rdy2", ready, 0);
    issue(1, 3'b001, 32'h103, 32'h55);
    chk("mis_sh", mis, 1); chk("mis_sh_wr", write, 0); chk("mis_sh_rdy", ready, 0);
    step(); chk("mis_sh_pulse", mis, 0); chk("mis_sh_wr2", write, 0);

    // start while awaiting data is dropped
    c0 = n_cmds;
    issue(0, 3'b010, 32'h40, 0);
    step();
    start = 1; is_store = 1; addr = 32'h80; f3 = 3'b010;
    step(); start = 0;
    chk("busy_start_wr", write, 0); chk("busy_start_busy", busy, 1);
    a2h = 32'h0BAD_F00D; rdv = 1;
    step(); rdv = 0; chk("busy_ld", load_data, 32'h0BAD_F00D);
    step(); chk("busy_cmds", n_cmds - c0, 1); chk("busy_wr_none", write, 0);

    // Reset during REQ
    waitreq = 1;
    issue(0, 3'b010, 32'h500, 0);
    chk("rq_read", read, 1);
    #1 rst_n = 0;
    #1 chk("rq_read_rst", read, 0); chk("rq_busy_rst", busy, 0); chk("rq_addr_rst", address, 0);
    step(); rst_n = 1; rdv = 1; a2h = 32'h1111_2222;
    step(); rdv = 0; waitreq = 0; chk("rq_no_ready", ready, 0);
    step(); chk("rq_no_ready2", ready, 0); chk("rq_idle", busy, 0); chk("rq_ld", load_data, 0);

    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
      start    = ($urandom % 4) == 0;
      is_store = $urandom % 2;
      f3       = 3'($urandom % 8);
      addr     = $urandom;
      sd       = $urandom;
      waitreq  = ($urandom % 3) == 0;
      rdv      = ($urandom % 3) == 0;
      a2h      = $urandom;
      step();
    end
    start = 0; rdv = 0; waitreq = 0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
